// File: rtl/multiplier_top.sv
// multiplier_top: sequential unsigned shift-add multiplier, N-bit operands,
// 2N-bit product. start (IDLE only) launches an operation; after N cycles
// the product appears on out with a one-cycle valid strobe.
// Optional: define MULT_BUSY_EN to add a busy output (high in CALC and DONE).
`timescale 1ns/1ps
module multiplier_top #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] out,
`ifdef MULT_BUSY_EN
  output logic           busy,
`endif
  output logic           valid
);

  localparam int              CW   = $clog2(N + 1);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  count;
  logic [2*N-1:0] acc_nxt;

  // Partial-product add for the current multiplier bit
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

`ifdef MULT_BUSY_EN
  assign busy = (state != IDLE);
`endif

  // Control FSM plus datapath registers; out is only written on the final
  // iteration, so a partial accumulator is never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      out    <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            mcand  <= {{N{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            out   <= acc_nxt;
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_top.sv
// Self-checking bench for multiplier_top (N=4): expected products and
// their due cycles go into a queue at stimulus time; a monitor records
// every valid strobe and each scenario task compares the two queues.
`timescale 1ns/1ps
module tb_multiplier_top;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic [2*N-1:0] out;
  logic           valid;
`ifdef MULT_BUSY_EN
  logic           busy;
  int             busy_cnt = 0;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int e0;

  logic [2*N-1:0] exp_out[$];
  int             exp_cyc[$];
  logic [2*N-1:0] obs_out[$];
  int             obs_cyc[$];

  multiplier_top #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
`ifdef MULT_BUSY_EN
    .busy  (busy),
`endif
    .valid (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every valid strobe with the cycle it appeared in
  always @(negedge clk) begin
    if (valid !== 1'b0) begin
      obs_out.push_back(out);
      obs_cyc.push_back(cyc);
    end
`ifdef MULT_BUSY_EN
    if (busy === 1'b1) busy_cnt++;
`endif
  end

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one start pulse (called just after a negedge); leaves e0 set to
  // the cycle index of the sampling edge and returns at the next negedge.
  task automatic pulse(input logic [N-1:0] av, input logic [N-1:0] bv);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_q();
    exp_out.delete(); exp_cyc.delete(); obs_out.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    chk_cnt++;
    if (out !== '0 || valid !== 1'b0) $display("FAIL reset_values out=%0d valid=%b want out=0 valid=0", out, valid);
    else pass_cnt++;
`ifdef MULT_BUSY_EN
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
    else pass_cnt++;
`endif
    #8 rst_n = 1'b1;        // released at t=20 (negedge)
    wait_neg(3);
    chk_cnt++;
    if (obs_out.size() != 0 || valid !== 1'b0) $display("FAIL reset_idle valids=%0d want 0", obs_out.size());
    else pass_cnt++;
    clear_q();
  endtask

  task automatic test_basic();
    logic [2*N-1:0] v, e; int c, ec;
    clear_q();
`ifdef MULT_BUSY_EN
    busy_cnt = 0;
`endif
    pulse(4'd2, 4'd2);
    exp_out.push_back(8'd4); exp_cyc.push_back(e0 + N);
    wait_neg(N + 3);
    chk_cnt++;
    if (obs_out.size() != exp_out.size()) $display("FAIL basic_count got=%0d want=%0d", obs_out.size(), exp_out.size());
    else pass_cnt++;
    while (obs_out.size() > 0 && exp_out.size() > 0) begin
      v = obs_out.pop_front(); c = obs_cyc.pop_front();
      e = exp_out.pop_front(); ec = exp_cyc.pop_front();
      chk_cnt++;
      if (v !== e || c != ec) $display("FAIL basic_result got=%0d@%0d want=%0d@%0d", v, c, e, ec);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out !== 8'd4 || valid !== 1'b0) $display("FAIL basic_hold out=%0d valid=%b want out=4 valid=0", out, valid);
    else pass_cnt++;
`ifdef MULT_BUSY_EN
    chk_cnt++;
    if (busy_cnt != N + 1) $display("FAIL busy_cycles got=%0d want=%0d", busy_cnt, N + 1);
    else pass_cnt++;
`endif
    clear_q();
  endtask

  task automatic test_max_zero();
    logic [2*N-1:0] v, e; int c, ec;
    clear_q();
    pulse(4'd15, 4'd15);
    exp_out.push_back(8'hE1); exp_cyc.push_back(e0 + N);
    wait_neg(N + 1);        // next start lands on the first IDLE edge
    pulse(4'd0, 4'd9);
    exp_out.push_back(8'd0); exp_cyc.push_back(e0 + N);
    wait_neg(N + 3);
    chk_cnt++;
    if (obs_out.size() != exp_out.size()) $display("FAIL maxzero_count got=%0d want=%0d", obs_out.size(), exp_out.size());
    else pass_cnt++;
    while (obs_out.size() > 0 && exp_out.size() > 0) begin
      v = obs_out.pop_front(); c = obs_cyc.pop_front();
      e = exp_out.pop_front(); ec = exp_cyc.pop_front();
      chk_cnt++;
      if (v !== e || c != ec) $display("FAIL maxzero_result got=%0d@%0d want=%0d@%0d", v, c, e, ec);
      else pass_cnt++;
    end
    clear_q();
  endtask

  task automatic test_ignore_start();
    logic [2*N-1:0] v, e; int c, ec;
    clear_q();
    pulse(4'd3, 4'd5);
    exp_out.push_back(8'd15); exp_cyc.push_back(e0 + N);
    wait_neg(1);
    a = 4'd7; b = 4'd7; start = 1'b1;   // sampled at E0+2, in CALC
    @(posedge clk); #1 start = 1'b0;
    wait_neg(N + 6);
    chk_cnt++;
    if (obs_out.size() != exp_out.size()) $display("FAIL ignore_count got=%0d want=%0d", obs_out.size(), exp_out.size());
    else pass_cnt++;
    while (obs_out.size() > 0 && exp_out.size() > 0) begin
      v = obs_out.pop_front(); c = obs_cyc.pop_front();
      e = exp_out.pop_front(); ec = exp_cyc.pop_front();
      chk_cnt++;
      if (v !== e || c != ec) $display("FAIL ignore_result got=%0d@%0d want=%0d@%0d", v, c, e, ec);
      else pass_cnt++;
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] v, e; int c, ec; int first;
    clear_q();
    pulse(4'd6, 4'd7);
    first = e0;
    exp_out.push_back(8'd42); exp_cyc.push_back(first + 4);
    wait_neg(5);
    pulse(4'd9, 4'd11);     // sampled at E0+6
    exp_out.push_back(8'd99); exp_cyc.push_back(first + 10);
    // random operands, each started on the first IDLE edge
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] ra, rb;
      ra = N'($urandom_range(0, 15)); rb = N'($urandom_range(0, 15));
      wait_neg(N + 1);
      pulse(ra, rb);
      exp_out.push_back(8'(ra) * 8'(rb)); exp_cyc.push_back(e0 + N);
    end
    wait_neg(N + 3);
    chk_cnt++;
    if (obs_out.size() != exp_out.size()) $display("FAIL b2b_count got=%0d want=%0d", obs_out.size(), exp_out.size());
    else pass_cnt++;
    while (obs_out.size() > 0 && exp_out.size() > 0) begin
      v = obs_out.pop_front(); c = obs_cyc.pop_front();
      e = exp_out.pop_front(); ec = exp_cyc.pop_front();
      chk_cnt++;
      if (v !== e || c != ec) $display("FAIL b2b_result got=%0d@%0d want=%0d@%0d", v, c, e, ec);
      else pass_cnt++;
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    logic [2*N-1:0] v, e; int c, ec;
    clear_q();
    pulse(4'd13, 4'd10);
    wait_neg(1);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (out !== '0 || valid !== 1'b0) $display("FAIL midreset_values out=%0d valid=%b want out=0 valid=0", out, valid);
    else pass_cnt++;
`ifdef MULT_BUSY_EN
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL midreset_busy got=%b want=0", busy);
    else pass_cnt++;
`endif
    @(negedge clk) rst_n = 1'b1;
    wait_neg(N + 4);
    chk_cnt++;
    if (obs_out.size() != 0 || out !== '0) $display("FAIL midreset_quiet valids=%0d out=%0d want 0 valids out=0", obs_out.size(), out);
    else pass_cnt++;
    clear_q();
    pulse(4'd4, 4'd5);
    exp_out.push_back(8'd20); exp_cyc.push_back(e0 + N);
    wait_neg(N + 3);
    chk_cnt++;
    if (obs_out.size() != exp_out.size()) $display("FAIL postreset_count got=%0d want=%0d", obs_out.size(), exp_out.size());
    else pass_cnt++;
    while (obs_out.size() > 0 && exp_out.size() > 0) begin
      v = obs_out.pop_front(); c = obs_cyc.pop_front();
      e = exp_out.pop_front(); ec = exp_cyc.pop_front();
      chk_cnt++;
      if (v !== e || c != ec) $display("FAIL postreset_result got=%0d@%0d want=%0d@%0d", v, c, e, ec);
      else pass_cnt++;
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
